axi_burst_ctrl: RTL and testbench
=================================

// Module: axi_burst_ctrl
// PURPOSE
//  Parametrised AXI4 master transfer controller; successor to the fixed 32-bit AXI3 control FSM.
//  Issues one INCR burst (read or write) per CTLExec request, drives AR/AW addr/len/size itself and counts beats.
//  Generates WLast internally, checks RLast against the beat count, and adds a handshake watchdog.
//  Sits between bus-controller front end (show-ahead data FIFOs) and the AXI interconnect.
// PARAMETERS
//  ADDR_W   32    AXI address width
//  DATA_W   32    AXI data width; power of 2, >=8; AxSIZE=log2(DATA_W/8)
//  LEN_W    8     burst length field width (AXI4: 8 -> up to 256 beats)
//  TMO_W    10    watchdog counter width; timeout after 2**TMO_W-1 idle cycles; TMO_EN=0 disables
//  TMO_EN   1     watchdog enable
// PORTS
//  AXIClock   in  1       clock
//  Reset_     in  1       async reset, active-low
//  AXIARValid/AXIARReady out/in 1; AXIARAddr out ADDR_W; AXIARLen out LEN_W; AXIARSize out 3; AXIARBurst out 2 (=01)
//  AXIRValid in 1; AXIRReady out 1; AXIRData in DATA_W; AXIRResp in 2; AXIRLast in 1
//  AXIAWValid/AXIAWReady out/in 1; AXIAWAddr out ADDR_W; AXIAWLen out LEN_W; AXIAWSize out 3; AXIAWBurst out 2 (=01)
//  AXIWValid out 1; AXIWReady in 1; AXIWData out DATA_W; AXIWStrb out DATA_W/8 (all 1); AXIWLast out 1
//  AXIBValid in 1; AXIBReady out 1; AXIBResp in 2
//  CTLExec    in  1       request; held high until CTLReady seen, low to finish
//  CTLWrite   in  1       1=write, 0=read; sampled with CTLExec in IDLE
//  CTLAddr    in  ADDR_W  start address; sampled in IDLE
//  CTLLen     in  LEN_W   beats-1; sampled in IDLE
//  CTLStart   out 1       1-cycle pulse on request acceptance
//  CTLReady   out 1       high in DONE/ERR while CTLExec high
//  CTLEnd     out 1       1-cycle pulse on DONE/ERR -> IDLE
//  CTLPutEn   out 1       read beat valid (good beats only); CTLPutData out DATA_W = AXIRData
//  CTLGetValid in 1       write FIFO non-empty; CTLGetData in DATA_W; CTLGetEn out 1 = AXIWValid&AXIWReady
//  CTLErr     out 3       000 ok,001 RSLVERR,010 RDECERR,011 BSLVERR,100 BDECERR,101 RLAST mismatch,110 timeout
// BEHAVIOUR
//  Reset: state IDLE; all AXI valid/ready, CTL pulses, CTLErr=0; addr/len regs 0.
//  AXI Valid outputs are Moore (state/flag regs only) - never depend combinationally on Ready.
//  States: IDLE, RADDR, RDATA, WXFER, WRESP, DONE, ERR, default->IDLE.
//  IDLE: CTLExec=1 -> latch addr/len/write, beat_cnt=0, CTLStart pulse -> RADDR or WXFER.
//  RADDR: ARValid=1, RReady=1; ARReady -> RDATA; R beat may arrive same cycle as AR handshake and is counted.
//  RDATA: RReady=1; each R handshake: beat_cnt++; resp>=2 -> latch first error, suppress PutEn for rest of burst;
//   RLast on beat_cnt==len -> DONE (or ERR if error latched); RLast early, or no RLast at beat len -> code 101, ERR
//   only after RLast (all beats always drained).
//  WXFER: AWValid until AW handshake (aw_done flag); WValid=CTLGetValid concurrently, independent of AW;
//   AXIWLast=(beat_cnt==len); W handshake with WLast -> w_done; aw_done&w_done -> WRESP.
//  WRESP: BReady=1; BValid -> resp>=2 ? ERR(code) : DONE.
//  DONE/ERR: CTLReady while CTLExec=1; CTLExec=0 -> CTLEnd pulse, -> IDLE. CTLErr held until next CTLStart.
//  Watchdog: counts cycles in RADDR/RDATA/WXFER/WRESP with no AXI handshake; clears on any handshake;
//   saturation -> ERR code 110, all valids drop (fatal; bus reset required).
//  Len=0: single beat, WLast on first beat, RLast expected on first beat.
//  CTLExec drop mid-transfer: ignored until DONE/ERR (burst cannot be aborted).
//  Reset_ low any time: immediate IDLE, outputs to reset values; no partial handshake completed.
//  Widths: beat_cnt LEN_W bits, never wraps (terminates at len); address not incremented by block (INCR by slave).
// STRUCTURE
//  Package axi_pkg: AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, CTLErr code localparams, state encoding.
//  One sub-module: axi_watchdog (counter, clear, enable, expire) - reusable by other AXI masters.
// TESTING
//  Read len=3 @0x1000, OKAY x4, RLast on 4th -> ARLen=3, 4 CTLPutEn, CTLReady, CTLEnd after Exec drop, CTLErr=0.
//  Write len=0, AWReady delayed 5 cycles after W handshake -> single WLast beat, WRESP only after AW, DONE.
//  Read len=3, beat1 RResp=10 -> PutEn only beat0, 4 beats drained, ERR, CTLErr=001.
//  Read len=3, RLast on beat 2 -> ERR, CTLErr=101; write with BResp=11 -> CTLErr=100.
//  Write len=7, CTLGetValid gaps + WReady stalls -> exactly 8 GetEn, WData order preserved, WLast on 8th only.
//  ARReady held 0 for 1023 cycles -> ERR CTLErr=110; Reset_ pulse in RDATA -> IDLE, all valids 0 next edge.

Source files
------------

// File: rtl/axi_burst_ctrl_pkg.sv
// Shared AXI4 encodings, controller status codes and FSM state type for the
// burst controller and its watchdog.
package axi_burst_ctrl_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] CTL_ERR_OK      = 3'b000;
    localparam logic [2:0] CTL_ERR_RSLV    = 3'b001;
    localparam logic [2:0] CTL_ERR_RDEC    = 3'b010;
    localparam logic [2:0] CTL_ERR_BSLV    = 3'b011;
    localparam logic [2:0] CTL_ERR_BDEC    = 3'b100;
    localparam logic [2:0] CTL_ERR_RLAST   = 3'b101;
    localparam logic [2:0] CTL_ERR_TMO     = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WXFER = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ctl_state_e;

    function automatic logic [2:0] resp_err_code(input logic [1:0] resp, input logic is_write);
        logic [2:0] code;
        code = CTL_ERR_OK;
        if (resp == AXI_RESP_SLVERR)
            code = is_write ? CTL_ERR_BSLV : CTL_ERR_RSLV;
        else if (resp == AXI_RESP_DECERR)
            code = is_write ? CTL_ERR_BDEC : CTL_ERR_RDEC;
        return code;
    endfunction

endpackage

// File: rtl/axi_burst_ctrl_watchdog.sv
// Handshake watchdog: down-counter reloaded while disabled or on any handshake;
// expire fires on the (2**TMO_W-1)-th consecutive idle cycle.
module axi_watchdog #(
    parameter int TMO_W = 10
) (
    input  logic AXIClock,
    input  logic Reset_,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam logic [TMO_W-1:0] CNT_LOAD = '1;

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge AXIClock or negedge Reset_) begin
        if (!Reset_)
            cnt <= CNT_LOAD;
        else if (!enable || clear)
            cnt <= CNT_LOAD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Terminal count at 1 so the expiring cycle is the last idle one, not one after.
    assign expire = enable & ~clear & (cnt == TMO_W'(1));

endmodule

// File: rtl/axi_burst_ctrl.sv
// AXI4 master burst controller: one INCR read or write burst per CTLExec request,
// with beat counting, RLast checking, internal WLast and a handshake watchdog.
module axi_burst_ctrl
    import axi_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int TMO_W  = 10,
    parameter bit TMO_EN = 1'b1
) (
    input  logic                AXIClock,
    input  logic                Reset_,
    output logic                AXIARValid,
    input  logic                AXIARReady,
    output logic [ADDR_W-1:0]   AXIARAddr,
    output logic [LEN_W-1:0]    AXIARLen,
    output logic [2:0]          AXIARSize,
    output logic [1:0]          AXIARBurst,
    input  logic                AXIRValid,
    output logic                AXIRReady,
    input  logic [DATA_W-1:0]   AXIRData,
    input  logic [1:0]          AXIRResp,
    input  logic                AXIRLast,
    output logic                AXIAWValid,
    input  logic                AXIAWReady,
    output logic [ADDR_W-1:0]   AXIAWAddr,
    output logic [LEN_W-1:0]    AXIAWLen,
    output logic [2:0]          AXIAWSize,
    output logic [1:0]          AXIAWBurst,
    output logic                AXIWValid,
    input  logic                AXIWReady,
    output logic [DATA_W-1:0]   AXIWData,
    output logic [DATA_W/8-1:0] AXIWStrb,
    output logic                AXIWLast,
    input  logic                AXIBValid,
    output logic                AXIBReady,
    input  logic [1:0]          AXIBResp,
    input  logic                CTLExec,
    input  logic                CTLWrite,
    input  logic [ADDR_W-1:0]   CTLAddr,
    input  logic [LEN_W-1:0]    CTLLen,
    output logic                CTLStart,
    output logic                CTLReady,
    output logic                CTLEnd,
    output logic                CTLPutEn,
    output logic [DATA_W-1:0]   CTLPutData,
    input  logic                CTLGetValid,
    input  logic [DATA_W-1:0]   CTLGetData,
    output logic                CTLGetEn,
    output logic [2:0]          CTLErr
);

    localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_W / 8));

    ctl_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              ar_valid;
    logic              r_ready;
    logic              aw_valid;
    logic              aw_done;
    logic              w_active;
    logic              b_ready;
    logic              ctl_start;
    logic              ctl_end;
    logic [2:0]        err_code;
    logic [2:0]        rd_err_next;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, at_last, busy, wdt_expire;

    assign ar_hs   = ar_valid & AXIARReady;
    assign r_hs    = AXIRValid & r_ready;
    assign aw_hs   = aw_valid & AXIAWReady;
    assign w_hs    = AXIWValid & AXIWReady;
    assign b_hs    = AXIBValid & b_ready;
    assign at_last = (beat_cnt == len_q);
    assign busy    = (state == ST_RADDR) || (state == ST_RDATA) ||
                     (state == ST_WXFER) || (state == ST_WRESP);

    axi_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .AXIClock (AXIClock),
        .Reset_   (Reset_),
        .enable   (busy && (TMO_EN != 1'b0)),
        .clear    (ar_hs | r_hs | aw_hs | w_hs | b_hs),
        .expire   (wdt_expire)
    );

    // First error of the burst wins; a bad response outranks an RLast mismatch on the same beat.
    always_comb begin
        rd_err_next = err_code;
        if (r_hs && (err_code == CTL_ERR_OK)) begin
            if (AXIRResp[1])
                rd_err_next = resp_err_code(AXIRResp, 1'b0);
            else if (AXIRLast != at_last)
                rd_err_next = CTL_ERR_RLAST;
        end
    end

    always_ff @(posedge AXIClock or negedge Reset_) begin
        if (!Reset_) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            aw_valid  <= 1'b0;
            aw_done   <= 1'b0;
            w_active  <= 1'b0;
            b_ready   <= 1'b0;
            ctl_start <= 1'b0;
            ctl_end   <= 1'b0;
            err_code  <= CTL_ERR_OK;
        end else begin
            ctl_start <= 1'b0;
            ctl_end   <= 1'b0;
            if (wdt_expire) begin
                state    <= ST_ERR;
                err_code <= CTL_ERR_TMO;
                ar_valid <= 1'b0;
                r_ready  <= 1'b0;
                aw_valid <= 1'b0;
                w_active <= 1'b0;
                b_ready  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (CTLExec) begin
                            addr_q    <= CTLAddr;
                            len_q     <= CTLLen;
                            beat_cnt  <= '0;
                            err_code  <= CTL_ERR_OK;
                            ctl_start <= 1'b1;
                            aw_done   <= 1'b0;
                            if (CTLWrite) begin
                                state    <= ST_WXFER;
                                aw_valid <= 1'b1;
                                w_active <= 1'b1;
                            end else begin
                                state    <= ST_RADDR;
                                ar_valid <= 1'b1;
                                r_ready  <= 1'b1;
                            end
                        end
                    end
                    ST_RADDR, ST_RDATA: begin
                        if (r_hs) begin
                            err_code <= rd_err_next;
                            if (!at_last)
                                beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (r_hs && AXIRLast) begin
                            ar_valid <= 1'b0;
                            r_ready  <= 1'b0;
                            state    <= (rd_err_next == CTL_ERR_OK) ? ST_DONE : ST_ERR;
                        end else if (ar_hs) begin
                            ar_valid <= 1'b0;
                            state    <= ST_RDATA;
                        end
                    end
                    ST_WXFER: begin
                        if (aw_hs) begin
                            aw_valid <= 1'b0;
                            aw_done  <= 1'b1;
                        end
                        if (w_hs) begin
                            if (at_last)
                                w_active <= 1'b0;
                            else
                                beat_cnt <= beat_cnt + 1'b1;
                        end
                        if ((aw_done || aw_hs) && (!w_active || (w_hs && at_last))) begin
                            state   <= ST_WRESP;
                            b_ready <= 1'b1;
                        end
                    end
                    ST_WRESP: begin
                        if (b_hs) begin
                            b_ready <= 1'b0;
                            if (AXIBResp[1]) begin
                                state    <= ST_ERR;
                                err_code <= resp_err_code(AXIBResp, 1'b1);
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        if (!CTLExec) begin
                            state   <= ST_IDLE;
                            ctl_end <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b0;
                        aw_valid <= 1'b0;
                        w_active <= 1'b0;
                        b_ready  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign AXIARValid = ar_valid;
    assign AXIARAddr  = addr_q;
    assign AXIARLen   = len_q;
    assign AXIARSize  = AX_SIZE;
    assign AXIARBurst = AXI_BURST_INCR;
    assign AXIRReady  = r_ready;

    assign AXIAWValid = aw_valid;
    assign AXIAWAddr  = addr_q;
    assign AXIAWLen   = len_q;
    assign AXIAWSize  = AX_SIZE;
    assign AXIAWBurst = AXI_BURST_INCR;

    // Show-ahead write FIFO: its head word is presented directly as W data.
    assign AXIWValid  = w_active & CTLGetValid;
    assign AXIWData   = CTLGetData;
    assign AXIWStrb   = '1;
    assign AXIWLast   = w_active & at_last;
    assign AXIBReady  = b_ready;

    assign CTLStart   = ctl_start;
    assign CTLEnd     = ctl_end;
    assign CTLErr     = err_code;
    assign CTLReady   = ((state == ST_DONE) || (state == ST_ERR)) & CTLExec;
    assign CTLPutEn   = r_hs & (err_code == CTL_ERR_OK) & ~AXIRResp[1];
    assign CTLPutData = AXIRData;
    assign CTLGetEn   = w_hs;

endmodule

// File: tb/tb_axi_burst_ctrl.sv
// Self-checking bench for axi_burst_ctrl: randomized AXI slave and FIFO behaviour
// checked against a burst-level reference model.
module tb_axi_burst_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NONE = 100000;

    logic          AXIClock = 1'b0;
    logic          Reset_   = 1'b0;
    logic          AXIARValid, AXIARReady;
    logic [AW-1:0] AXIARAddr;
    logic [LW-1:0] AXIARLen;
    logic [2:0]    AXIARSize;
    logic [1:0]    AXIARBurst;
    logic          AXIRValid, AXIRReady, AXIRLast;
    logic [DW-1:0] AXIRData;
    logic [1:0]    AXIRResp;
    logic          AXIAWValid, AXIAWReady;
    logic [AW-1:0] AXIAWAddr;
    logic [LW-1:0] AXIAWLen;
    logic [2:0]    AXIAWSize;
    logic [1:0]    AXIAWBurst;
    logic          AXIWValid, AXIWReady, AXIWLast;
    logic [DW-1:0] AXIWData;
    logic [DW/8-1:0] AXIWStrb;
    logic          AXIBValid, AXIBReady;
    logic [1:0]    AXIBResp;
    logic          CTLExec, CTLWrite, CTLStart, CTLReady, CTLEnd, CTLPutEn, CTLGetValid, CTLGetEn;
    logic [AW-1:0] CTLAddr;
    logic [LW-1:0] CTLLen;
    logic [DW-1:0] CTLPutData, CTLGetData;
    logic [2:0]    CTLErr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] bdata[$];
    logic [1:0]    bresp[$];

    always #5 AXIClock = ~AXIClock;

    axi_burst_ctrl dut (
        .AXIClock(AXIClock), .Reset_(Reset_),
        .AXIARValid(AXIARValid), .AXIARReady(AXIARReady), .AXIARAddr(AXIARAddr),
        .AXIARLen(AXIARLen), .AXIARSize(AXIARSize), .AXIARBurst(AXIARBurst),
        .AXIRValid(AXIRValid), .AXIRReady(AXIRReady), .AXIRData(AXIRData),
        .AXIRResp(AXIRResp), .AXIRLast(AXIRLast),
        .AXIAWValid(AXIAWValid), .AXIAWReady(AXIAWReady), .AXIAWAddr(AXIAWAddr),
        .AXIAWLen(AXIAWLen), .AXIAWSize(AXIAWSize), .AXIAWBurst(AXIAWBurst),
        .AXIWValid(AXIWValid), .AXIWReady(AXIWReady), .AXIWData(AXIWData),
        .AXIWStrb(AXIWStrb), .AXIWLast(AXIWLast),
        .AXIBValid(AXIBValid), .AXIBReady(AXIBReady), .AXIBResp(AXIBResp),
        .CTLExec(CTLExec), .CTLWrite(CTLWrite), .CTLAddr(CTLAddr), .CTLLen(CTLLen),
        .CTLStart(CTLStart), .CTLReady(CTLReady), .CTLEnd(CTLEnd),
        .CTLPutEn(CTLPutEn), .CTLPutData(CTLPutData),
        .CTLGetValid(CTLGetValid), .CTLGetData(CTLGetData), .CTLGetEn(CTLGetEn),
        .CTLErr(CTLErr)
    );

    task automatic clear_inputs();
        AXIARReady = 0; AXIRValid = 0; AXIRData = '0; AXIRResp = 0; AXIRLast = 0;
        AXIAWReady = 0; AXIWReady = 0; AXIBValid = 0; AXIBResp = 0;
        CTLExec = 0; CTLWrite = 0; CTLAddr = '0; CTLLen = '0;
        CTLGetValid = 0; CTLGetData = '0;
    endtask

    task automatic issue(input string name, input logic wr, input logic [AW-1:0] addr, input int len);
        @(negedge AXIClock);
        CTLExec = 1; CTLWrite = wr; CTLAddr = addr; CTLLen = LW'(len);
        @(negedge AXIClock);
        n_checks++;
        if (CTLStart !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_pulse: CTLStart=%b expected 1", name, CTLStart);
        end
        // Request fields must have been latched; scramble them.
        CTLAddr = $urandom; CTLLen = LW'($urandom); CTLWrite = ~wr;
    endtask

    task automatic finish_xfer(input string name, input logic [2:0] exp_code);
        CTLExec = 0;
        @(negedge AXIClock);
        n_checks++;
        if (CTLEnd !== 1'b1 || CTLReady !== 1'b0 || CTLErr !== exp_code) begin
            n_fail++;
            $display("FAIL %s end_pulse: CTLEnd=%b CTLReady=%b CTLErr=%0d expected 1/0/%0d",
                     name, CTLEnd, CTLReady, CTLErr, exp_code);
        end
        @(negedge AXIClock);
        n_checks++;
        if (CTLEnd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_single: CTLEnd=%b expected 0", name, CTLEnd);
        end
    endtask

    // Read burst: beats 0..last_idx, RLast on last_idx only; bad_beat carries bad_resp.
    task automatic run_read(input string name, input logic [AW-1:0] addr, input int len,
                            input int last_idx, input int bad_beat, input logic [1:0] bad_resp);
        logic [DW-1:0] exp_puts[$];
        logic [DW-1:0] got_puts[$];
        logic [2:0]    exp_code;
        int err_beat, mm_beat, idx, ar_cnt, n_put;
        bit ar_done, ready_seen, addr_bad, put_bad;
        bdata.delete(); bresp.delete();
        for (int i = 0; i <= last_idx; i++) begin
            bdata.push_back($urandom);
            bresp.push_back(i == bad_beat ? bad_resp : 2'($urandom_range(0, 1)));
        end
        // Reference: the earliest detectable error decides the code; good data stops there.
        err_beat = (bad_beat >= 0) ? bad_beat : NONE;
        mm_beat  = (last_idx == len) ? NONE : ((last_idx < len) ? last_idx : len);
        if (err_beat != NONE && err_beat <= mm_beat) begin
            exp_code = (bad_resp == 2'b10) ? 3'd1 : 3'd2;
            n_put = err_beat;
        end else if (mm_beat != NONE) begin
            exp_code = 3'd5;
            n_put = mm_beat + 1;
        end else begin
            exp_code = 3'd0;
            n_put = last_idx + 1;
        end
        for (int i = 0; i < n_put; i++) exp_puts.push_back(bdata[i]);

        issue(name, 1'b0, addr, len);
        idx = 0; ar_cnt = 0; ar_done = 0; ready_seen = 0; addr_bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (CTLReady) begin ready_seen = 1; break; end
            AXIARReady = AXIARValid && !ar_done && ($urandom_range(0, 2) == 0);
            AXIRValid  = (idx <= last_idx) && (ar_done || AXIARReady) && ($urandom_range(0, 3) != 0);
            AXIRData   = (idx <= last_idx) ? bdata[idx] : '0;
            AXIRResp   = (idx <= last_idx) ? bresp[idx] : 2'b00;
            AXIRLast   = (idx == last_idx);
            #1;
            if (AXIARValid && AXIARReady) begin
                ar_done = 1; ar_cnt++;
                if (AXIARAddr !== addr || AXIARLen !== LW'(len) || AXIARSize !== 3'd2 || AXIARBurst !== 2'b01)
                    addr_bad = 1;
            end
            if (AXIRValid && AXIRReady) begin
                if (CTLPutEn) got_puts.push_back(CTLPutData);
                idx++;
            end
            @(negedge AXIClock);
        end
        AXIARReady = 0; AXIRValid = 0; AXIRLast = 0;

        n_checks++;
        if (!ready_seen) begin
            n_fail++;
            $display("FAIL %s ready_timeout: CTLReady never seen, beats=%0d", name, idx);
        end
        n_checks++;
        if (CTLErr !== exp_code) begin
            n_fail++;
            $display("FAIL %s err_code: CTLErr=%0d expected %0d", name, CTLErr, exp_code);
        end
        put_bad = (got_puts.size() != exp_puts.size());
        if (!put_bad) foreach (exp_puts[i]) if (got_puts[i] !== exp_puts[i]) put_bad = 1;
        n_checks++;
        if (put_bad) begin
            n_fail++;
            $display("FAIL %s put_data: got %0d puts expected %0d (or data order wrong)",
                     name, got_puts.size(), exp_puts.size());
        end
        n_checks++;
        if (idx != last_idx + 1 || ar_cnt != 1 || addr_bad) begin
            n_fail++;
            $display("FAIL %s drain_ar: beats=%0d expected %0d, ar_hs=%0d expected 1, ar_fields_bad=%0d",
                     name, idx, last_idx + 1, ar_cnt, addr_bad);
        end
        finish_xfer(name, exp_code);
    endtask

    // Write burst: aw_delay>=0 holds AWReady until that many cycles after the WLast handshake.
    task automatic run_write(input string name, input logic [AW-1:0] addr, input int len,
                             input int aw_delay, input int gap_pct, input int stall_pct,
                             input logic [1:0] b_resp);
        logic [DW-1:0] wdata[$];
        logic [2:0] exp_code;
        int widx, gets, aw_cnt, w_done_cyc;
        bit aw_done, w_done, b_given, bv_hold, ready_seen;
        bit data_bad, last_bad, geten_bad, early_b, aw_bad;
        for (int i = 0; i <= len; i++) wdata.push_back($urandom);
        exp_code = (b_resp == 2'b10) ? 3'd3 : (b_resp == 2'b11) ? 3'd4 : 3'd0;

        issue(name, 1'b1, addr, len);
        widx = 0; gets = 0; aw_cnt = 0; w_done_cyc = 0;
        aw_done = 0; w_done = 0; b_given = 0; bv_hold = 0; ready_seen = 0;
        data_bad = 0; last_bad = 0; geten_bad = 0; early_b = 0; aw_bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (CTLReady) begin ready_seen = 1; break; end
            if (AXIBReady && !(aw_done && w_done)) early_b = 1;
            if (aw_delay >= 0)
                AXIAWReady = AXIAWValid && !aw_done && w_done && (cyc >= w_done_cyc + aw_delay);
            else
                AXIAWReady = AXIAWValid && !aw_done && ($urandom_range(0, 2) == 0);
            CTLGetValid = (widx <= len) && (int'($urandom_range(0, 99)) >= gap_pct);
            CTLGetData  = (widx <= len) ? wdata[widx] : '0;
            AXIWReady   = int'($urandom_range(0, 99)) >= stall_pct;
            AXIBValid   = bv_hold || (aw_done && w_done && !b_given && ($urandom_range(0, 1) == 1));
            AXIBResp    = b_resp;
            #1;
            if (CTLGetEn !== (AXIWValid && AXIWReady) || (AXIWValid && !CTLGetValid)) geten_bad = 1;
            if (AXIAWValid && AXIAWReady) begin
                aw_done = 1; aw_cnt++;
                if (AXIAWAddr !== addr || AXIAWLen !== LW'(len) || AXIAWSize !== 3'd2 || AXIAWBurst !== 2'b01)
                    aw_bad = 1;
            end
            if (AXIWValid && AXIWReady) begin
                if (widx > len || AXIWData !== wdata[widx] || AXIWStrb !== 4'hF) data_bad = 1;
                if (AXIWLast !== (widx == len)) last_bad = 1;
                gets++;
                if (widx == len) begin w_done = 1; w_done_cyc = cyc; end
                widx++;
            end
            if (AXIBValid && AXIBReady) begin b_given = 1; bv_hold = 0; end
            else bv_hold = AXIBValid;
            @(negedge AXIClock);
        end
        AXIAWReady = 0; AXIWReady = 0; AXIBValid = 0; CTLGetValid = 0;

        n_checks++;
        if (!ready_seen || !b_given) begin
            n_fail++;
            $display("FAIL %s ready_timeout: ready_seen=%0d b_handshake=%0d", name, ready_seen, b_given);
        end
        n_checks++;
        if (CTLErr !== exp_code) begin
            n_fail++;
            $display("FAIL %s err_code: CTLErr=%0d expected %0d", name, CTLErr, exp_code);
        end
        n_checks++;
        if (gets != len + 1 || data_bad || last_bad) begin
            n_fail++;
            $display("FAIL %s w_beats: beats=%0d expected %0d data_bad=%0d wlast_bad=%0d",
                     name, gets, len + 1, data_bad, last_bad);
        end
        n_checks++;
        if (geten_bad || early_b || aw_cnt != 1 || aw_bad) begin
            n_fail++;
            $display("FAIL %s handshake_order: geten_bad=%0d bready_early=%0d aw_hs=%0d expected 1 aw_fields_bad=%0d",
                     name, geten_bad, early_b, aw_cnt, aw_bad);
        end
        finish_xfer(name, exp_code);
    endtask

    task automatic check_quiet(input string name);
        logic [9:0] flags;
        flags = {AXIARValid, AXIRReady, AXIAWValid, AXIWValid, AXIBReady,
                 CTLStart, CTLEnd, CTLReady, CTLPutEn, CTLGetEn};
        n_checks++;
        if (flags !== 10'b0 || CTLErr !== 3'd0 || AXIARAddr !== '0 || AXIARLen !== '0) begin
            n_fail++;
            $display("FAIL %s reset_outputs: flags=%b CTLErr=%0d ARAddr=%h ARLen=%0d expected all 0",
                     name, flags, CTLErr, AXIARAddr, AXIARLen);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset_ = 0;
        #1;
        check_quiet("reset");
        n_checks++;
        if (AXIARSize !== 3'd2 || AXIAWBurst !== 2'b01 || AXIWStrb !== 4'hF) begin
            n_fail++;
            $display("FAIL reset constants: ARSize=%0d AWBurst=%b WStrb=%h expected 2/01/F",
                     AXIARSize, AXIAWBurst, AXIWStrb);
        end
        repeat (3) @(negedge AXIClock);
        Reset_ = 1;
        @(negedge AXIClock);
        check_quiet("reset_release");
    endtask

    task automatic test_read_basic();
        run_read("read_ok_len3", 32'h0000_1000, 3, 3, -1, 2'b00);
        run_read("read_ok_len0", 32'h0000_2000, 0, 0, -1, 2'b00);
    endtask

    task automatic test_read_errors();
        run_read("read_slverr_beat1", 32'h0000_3000, 3, 3, 1, 2'b10);
        run_read("read_decerr_beat0", 32'h0000_3100, 2, 2, 0, 2'b11);
        run_read("read_rlast_early",  32'h0000_4000, 3, 2, -1, 2'b00);
        run_read("read_rlast_missing", 32'h0000_4100, 1, 3, -1, 2'b00);
    endtask

    task automatic test_write();
        run_write("write_len0_aw_late", 32'h0000_5000, 0, 5, 0, 0, 2'b00);
        run_write("write_len7_gaps",    32'h0000_6000, 7, -1, 40, 40, 2'b01);
        run_write("write_bdecerr",      32'h0000_7000, 2, -1, 10, 10, 2'b11);
        run_write("write_bslverr",      32'h0000_7100, 1, -1, 10, 10, 2'b10);
    endtask

    task automatic test_back_to_back();
        int len, bad;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                run_write("rand_write", $urandom, len, -1, 30, 30, 2'($urandom_range(0, 3)));
            end else begin
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
                run_read("rand_read", $urandom, len, len, bad, 2'($urandom_range(2, 3)));
            end
        end
    endtask

    task automatic test_timeout();
        int first;
        issue("timeout", 1'b0, 32'h0000_8000, 3);
        first = -1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge AXIClock);
            if (CTLReady) begin first = k; break; end
        end
        n_checks++;
        if (first != 1023) begin
            n_fail++;
            $display("FAIL timeout latency: ERR after %0d idle cycles expected 1023", first);
        end
        n_checks++;
        if (CTLErr !== 3'd6 || AXIARValid !== 1'b0 || AXIRReady !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout state: CTLErr=%0d ARValid=%b RReady=%b expected 6/0/0",
                     CTLErr, AXIARValid, AXIRReady);
        end
        finish_xfer("timeout", 3'd6);
    endtask

    task automatic test_reset_in_rdata();
        issue("reset_rdata", 1'b0, 32'h0000_9000, 3);
        AXIARReady = 1;
        @(negedge AXIClock);
        AXIARReady = 0;
        AXIRValid = 1; AXIRData = $urandom; AXIRResp = 2'b00; AXIRLast = 0;
        @(negedge AXIClock);
        AXIRValid = 0;
        #2;
        Reset_ = 0;
        #1;
        check_quiet("reset_rdata_async");
        CTLExec = 0;
        @(posedge AXIClock);
        #1;
        check_quiet("reset_rdata_edge");
        @(negedge AXIClock);
        Reset_ = 1;
        @(negedge AXIClock);
        check_quiet("reset_rdata_idle");
        run_read("read_after_reset", 32'h0000_A000, 2, 2, -1, 2'b00);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_errors();
        test_write();
        test_back_to_back();
        test_timeout();
        test_reset_in_rdata();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
